serv_mem_arbiter: RTL

- Shares one Wishbone memory port between the SERV instruction fetch path (downstream of the misalignment realigner) and the SERV data bus.
- Registered two-state-plus-idle grant FSM.
- Round-robin tie-break.
- Grant held until ack or requester abort.
- Sits between core/realigner and the single-ported memory or ROM controller.

---
 rtl/serv_arb_pkg.sv | 6 +
 rtl/serv_mem_arbiter_if.sv | 34 +++
 rtl/serv_arb_timeout.sv | 15 +
 rtl/serv_mem_arbiter.sv | 61 ++++++
 4 files changed

// File: rtl/serv_arb_pkg.sv
// serv_arb_pkg: grant state encoding, fetch byte-enable and watchdog width for serv_mem_arbiter
package serv_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_IBUS = 2'd1, ST_DBUS = 2'd2} state_t;
  localparam logic [3:0] IBUS_SEL = 4'hF;
  localparam int CNT_W = 16;
endpackage

// File: rtl/serv_mem_arbiter_if.sv
// serv_mem_arbiter_if: fetch, data and shared memory port signals; slave = arbiter side
interface serv_mem_arbiter_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        o_ibus_err;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        o_dbus_err;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_busy;
  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_ibus_err, o_dbus_rdt, o_dbus_ack, o_dbus_err,
           o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_busy
  );
  modport master (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_ibus_err, o_dbus_rdt, o_dbus_ack, o_dbus_err,
           o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_busy
  );
endinterface

// File: rtl/serv_arb_timeout.sv
// serv_arb_timeout: grant watchdog; expired once TIMEOUT_CYCLES-1 unacked granted cycles have elapsed
module serv_arb_timeout import serv_arb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter: round-robin share of one Wishbone port between SERV fetch and data buses.
// Define SERV_ARB_TIMEOUT_EN to abort grants that wait TIMEOUT_CYCLES without ack (ack+err pulse).
module serv_mem_arbiter import serv_arb_pkg::*; #(
  parameter bit DBUS_FIRST     = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  serv_mem_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic in_i, in_d, tmo, ack_i, ack_d;
  // Grant is only live while the owner still holds cyc; reset masks everything
  assign in_i = state_q == ST_IBUS && bus.i_ibus_cyc && !rst;
  assign in_d = state_q == ST_DBUS && bus.i_dbus_cyc && !rst;
`ifdef SERV_ARB_TIMEOUT_EN
  serv_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .clr(state_q == ST_IDLE), .en(in_i || in_d), .expired(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  assign ack_i = in_i && (bus.i_wb_ack || tmo);
  assign ack_d = in_d && (bus.i_wb_ack || tmo);
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (state_q == ST_IDLE) begin
      if (bus.i_dbus_cyc && !(bus.i_ibus_cyc && last_d_q)) begin
        state_d  = ST_DBUS;
        last_d_d = 1'b1;
      end else if (bus.i_ibus_cyc) begin
        state_d  = ST_IBUS;
        last_d_d = 1'b0;
      end
    end else if (state_q == ST_IBUS ? !bus.i_ibus_cyc || ack_i :
                 state_q == ST_DBUS ? !bus.i_dbus_cyc || ack_d : 1'b1)
      state_d = ST_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      last_d_q <= !DBUS_FIRST;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  assign bus.o_wb_cyc   = in_i || in_d;
  assign bus.o_wb_adr   = state_q == ST_DBUS ? bus.i_dbus_adr : bus.i_ibus_adr;
  assign bus.o_wb_dat   = state_q == ST_DBUS ? bus.i_dbus_dat : '0;
  assign bus.o_wb_sel   = state_q == ST_DBUS ? bus.i_dbus_sel : IBUS_SEL;
  assign bus.o_wb_we    = state_q == ST_DBUS && bus.i_dbus_we;
  assign bus.o_ibus_rdt = bus.i_wb_rdt;
  assign bus.o_dbus_rdt = bus.i_wb_rdt;
  assign bus.o_ibus_ack = ack_i;
  assign bus.o_dbus_ack = ack_d;
  assign bus.o_ibus_err = in_i && tmo && !bus.i_wb_ack;
  assign bus.o_dbus_err = in_d && tmo && !bus.i_wb_ack;
  assign bus.o_busy     = state_q != ST_IDLE && !rst;
endmodule
